// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset vector and fetch FSM states.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
   localparam logic [XLEN-1:0] PC_ALIGN_MASK        = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_adder.sv
// Sequential PC increment; wraps modulo 2^XLEN.
module pc_adder
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next
);

   assign pc_next = pc + PC_STEP;

endmodule

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry decode buffer.
// Optional IFETCH_MISALIGN_CHECK_EN reports misaligned redirect targets on misalign_fault.
module ifetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   input  logic            if_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misalign_fault
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_inc;
   logic            drop_q, drop_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic            fetch_enable_q;
   logic            req_fire;
   logic [XLEN-1:0] redirect_target;

   pc_adder u_pc_adder (
      .pc      (pc_q),
      .pc_next (pc_inc)
   );

   // Holds requests off until the first clock edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fetch_enable_q <= 1'b0;
      else        fetch_enable_q <= 1'b1;
   end

   assign imem_req_valid  = fetch_enable_q && (state_q == FETCH_REQ);
   assign imem_req_addr   = pc_q;
   assign req_fire        = imem_req_valid && imem_req_ready;
   assign redirect_target = redirect_pc & PC_ALIGN_MASK;

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_instr = if_instr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH_REQ;
      else        state_q <= state_d;
   end

   // Redirects win in every state; drop marks a response already in flight that must be discarded.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;

      if (redirect_valid) begin
         pc_d       = redirect_target;
         if_valid_d = 1'b0;
         state_d    = FETCH_REQ;
         case (state_q)
            FETCH_REQ: begin
               if (req_fire) begin
                  drop_d  = 1'b1;
                  state_d = FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (imem_rsp_valid) begin
                  drop_d = 1'b0;
               end else begin
                  drop_d  = 1'b1;
                  state_d = FETCH_WAIT;
               end
            end
            default: ;
         endcase
      end else begin
         case (state_q)
            FETCH_REQ: begin
               if (req_fire) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = FETCH_REQ;
                  end else begin
                     if_instr_d = imem_rsp_data;
                     if_pc_d    = pc_q;
                     if_valid_d = 1'b1;
                     pc_d       = pc_inc;
                     state_d    = FETCH_HOLD;
                  end
               end
            end
            FETCH_HOLD: begin
               if (if_ready) begin
                  if_valid_d = 1'b0;
                  state_d    = FETCH_REQ;
               end
            end
            default: state_d = FETCH_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         drop_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else begin
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
      end
   end

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
   end

   assign misalign_fault = misalign_q;
`else
   assign misalign_fault = 1'b0;
`endif

endmodule
